// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
//  Bundles every signal the fetch stage exchanges with its neighbours:
//   - pc_ctrl      : o_pc_mode / o_pc_cur / o_pc_branch out, i_pc_next back
//   - instr memory : o_imem_en / o_imem_addr out, i_imem_rdata back (1-cycle)
//   - decode       : o_instr / o_instr_pc / o_instr_valid out, i_instr_ready back
//   - execute      : i_branch_valid / i_branch_pc / i_branch_offset in
//  Member names are written from the fetch stage's point of view, so the
//  o_* members are driven by the fetch stage and the i_* members by the
//  surrounding blocks.
//  modport master : the fetch stage itself
//  modport slave  : the surrounding pc_ctrl / memory / decode / execute side
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
   parameter int ADDR_W = 12
);
   // pc_ctrl
   logic [1:0]        o_pc_mode;
   logic [31:0]       o_pc_cur;
   logic [31:0]       o_pc_branch;
   logic [31:0]       i_pc_next;
   // instruction memory
   logic              o_imem_en;
   logic [ADDR_W-1:0] o_imem_addr;
   logic [15:0]       i_imem_rdata;
   // decode
   logic [15:0]       o_instr;
   logic [31:0]       o_instr_pc;
   logic              o_instr_valid;
   logic              i_instr_ready;
   // execute redirect
   logic              i_branch_valid;
   logic [31:0]       i_branch_pc;
   logic [31:0]       i_branch_offset;

   modport master (
      output o_pc_mode, o_pc_cur, o_pc_branch,
      input  i_pc_next,
      output o_imem_en, o_imem_addr,
      input  i_imem_rdata,
      output o_instr, o_instr_pc, o_instr_valid,
      input  i_instr_ready,
      input  i_branch_valid, i_branch_pc, i_branch_offset
   );

   modport slave (
      input  o_pc_mode, o_pc_cur, o_pc_branch,
      output i_pc_next,
      input  o_imem_en, o_imem_addr,
      output i_imem_rdata,
      input  o_instr, o_instr_pc, o_instr_valid,
      output i_instr_ready,
      output i_branch_valid, i_branch_pc, i_branch_offset
   );
endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//  Fetch stage. Owns the architectural fetch PC, asks pc_ctrl for the next PC
//  every cycle, reads 16-bit instructions from a synchronous instruction memory
//  and buffers {pc, instr} pairs in a small FIFO that decode drains through a
//  valid/ready handshake. A branch redirect from execute flushes the buffer,
//  drops any read still in flight and restarts fetching at the target.
//
// Parameters
//  MEM_DEPTH   instruction memory depth in 16-bit words
//  FIFO_DEPTH  fetch buffer entries (power of two, >= 2)
//  RESET_PC    fetch PC after reset (even)
//
// Ports
//  i_clk   in  clock, all state updates on the rising edge
//  i_rst   in  synchronous reset, active-high
//  bus     master modport of instr_fetch_if:
//          o_pc_mode   00 stall / 01 sequential (+2) / 10 branch, to pc_ctrl
//          o_pc_cur    PC handed to pc_ctrl (fetch PC, or branch PC on redirect)
//          o_pc_branch branch byte offset to pc_ctrl, zero unless redirecting
//          i_pc_next   next PC computed by pc_ctrl, loaded into the fetch PC
//          o_imem_en   memory read strobe
//          o_imem_addr word address, fetch PC bits [ADDR_W:1]
//          i_imem_rdata read data, valid the cycle after o_imem_en
//          o_instr / o_instr_pc / o_instr_valid  FIFO head towards decode
//          i_instr_ready  decode accepts the head
//          i_branch_valid / i_branch_pc / i_branch_offset  redirect request
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int          MEM_DEPTH  = 4096,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   instr_fetch_if.master bus
);

   localparam int ADDR_W = $clog2(MEM_DEPTH);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int SUM_W  = CNT_W + 1;
   localparam int ENT_W  = 48;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [31:0]      pc_reg;           // architectural fetch PC
   logic             inflight_reg;     // a memory read returns this cycle
   logic [31:0]      inflight_pc_reg;  // PC of that read, paired with its data
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;

   // -------------------------------------------------------------------------
   // Per-cycle decision
   // -------------------------------------------------------------------------
   logic             branch_w;
   logic             head_valid_w;
   logic             pop_w;
   logic             push_w;
   logic             fetch_w;
   logic [SUM_W-1:0] used_w;
   logic [SUM_W-1:0] avail_w;

   // A redirect cycle never transfers to decode: the head is about to be
   // flushed, so offering it would hand decode a wrong-path instruction.
   assign branch_w     = ~i_rst & bus.i_branch_valid;
   assign head_valid_w = ~i_rst & ~bus.i_branch_valid & (count_reg != '0);
   assign pop_w        = head_valid_w & bus.i_instr_ready;

   // Credit check: a new read may only be issued if its data is guaranteed a
   // slot, counting the read already in flight and the slot freed by a pop
   // this cycle. Written as used < capacity + pop so nothing goes negative.
   assign used_w  = SUM_W'(count_reg) + SUM_W'(inflight_reg);
   assign avail_w = SUM_W'(FIFO_DEPTH) + SUM_W'(pop_w);
   assign fetch_w = ~i_rst & ~bus.i_branch_valid & (used_w < avail_w);

   // Returning data is captured unless a redirect happens in the very cycle it
   // arrives; the flush takes precedence and the stale word is dropped.
   assign push_w = ~i_rst & inflight_reg & ~bus.i_branch_valid;

   // -------------------------------------------------------------------------
   // pc_ctrl and memory request
   // -------------------------------------------------------------------------
   always_comb begin
      bus.o_pc_mode   = 2'b00;
      bus.o_pc_cur    = pc_reg;
      bus.o_pc_branch = 32'h0;
      bus.o_imem_en   = 1'b0;
      if (branch_w) begin
         bus.o_pc_mode   = 2'b10;
         bus.o_pc_cur    = bus.i_branch_pc;
         bus.o_pc_branch = bus.i_branch_offset;
      end else if (fetch_w) begin
         bus.o_pc_mode   = 2'b01;
         bus.o_imem_en   = 1'b1;
      end
   end

   // Bit 0 of the PC never addresses memory; wrap of the low bits is pc_ctrl's
   // job, so the address is a plain slice of the fetch PC.
   assign bus.o_imem_addr = pc_reg[ADDR_W:1];

   // -------------------------------------------------------------------------
   // Fetch PC, in-flight tracking and FIFO bookkeeping
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc_reg          <= RESET_PC;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= RESET_PC;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
      end else begin
         // pc_ctrl already returns the right value for every mode: the
         // target on a redirect, pc+2 on a fetch and the same PC on a stall.
         pc_reg       <= bus.i_pc_next;
         inflight_reg <= fetch_w;
         if (fetch_w) begin
            inflight_pc_reg <= pc_reg;
         end
         if (branch_w) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (push_w) begin
               wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_w) begin
               rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push_w) - CNT_W'(pop_w);
         end
      end
   end

   // -------------------------------------------------------------------------
   // FIFO storage: one register slot per entry. The head is read
   // combinationally so it is visible the cycle after it is written and stays
   // put while decode back-pressures.
   // -------------------------------------------------------------------------
   logic [ENT_W-1:0] slot_w [FIFO_DEPTH];
   logic [ENT_W-1:0] head_w;

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
         logic [ENT_W-1:0] slot_reg;
         always_ff @(posedge i_clk) begin
            if (push_w && (wr_ptr_reg == PTR_W'(gi))) begin
               slot_reg <= {inflight_pc_reg, bus.i_imem_rdata};
            end
         end
         assign slot_w[gi] = slot_reg;
      end
   endgenerate

   assign head_w            = slot_w[rd_ptr_reg];
   assign bus.o_instr_pc    = head_w[ENT_W-1:16];
   assign bus.o_instr       = head_w[15:0];
   assign bus.o_instr_valid = head_valid_w;

   // The credit check makes a push into a full buffer impossible unless the
   // head leaves in the same cycle; anything else is a logic error.
   a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
      !(push_w && !pop_w && (count_reg == CNT_W'(FIFO_DEPTH))));

endmodule
